// File: rtl/pulse_to_level.sv
// Stretches one-cycle event strobes into level pulses with
// guaranteed high time, low gap and a queue of pending events.
module pulse_to_level #(
  parameter int HOLD_CYCLES = 4,
  parameter int GAP_CYCLES  = 1,
  parameter int PEND_W      = 4
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              pulse_i,
  input  logic              clr_i,
  output logic              level_o,
  output logic              busy_o,
  output logic              done_o,
  output logic [PEND_W-1:0] pend_o,
  output logic              ovf_o
);

  localparam int CMAX =
    ((HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES) - 1;
  localparam int CW = (CMAX < 1) ? 1 : $clog2(CMAX + 1);

  localparam logic [CW-1:0] HOLD_LD = CW'(HOLD_CYCLES - 1);
  localparam logic [CW-1:0] GAP_LD  = CW'(GAP_CYCLES - 1);
  localparam logic [PEND_W-1:0] PMAX = '1;

  typedef enum logic [1:0] {
    IDLE,
    HIGH,
    GAP
  } state_t;

  state_t            state_q;
  logic [CW-1:0]     cnt_q;
  logic [PEND_W-1:0] pend_q;
  logic              level_q;
  logic              busy_q;
  logic              done_q;
  logic              ovf_q;

  logic cnt_zero;
  logic has_pend;
  logic launch;
  logic inc;
  logic dec;

  assign cnt_zero = (cnt_q == '0);
  assign has_pend = (pend_q != '0);

  // A launch consumes either a queued event or the live strobe.
  assign launch = (state_q == GAP) && cnt_zero
                && (has_pend || pulse_i);

  assign inc = pulse_i && ((state_q == HIGH)
             || ((state_q == GAP) && !launch));

  assign dec = launch && has_pend && !pulse_i;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      pend_q  <= '0;
      level_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else if (clr_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      pend_q  <= '0;
      level_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (pulse_i) begin
            state_q <= HIGH;
            cnt_q   <= HOLD_LD;
            level_q <= 1'b1;
            busy_q  <= 1'b1;
          end
        end
        HIGH: begin
          if (cnt_zero) begin
            state_q <= GAP;
            cnt_q   <= GAP_LD;
            level_q <= 1'b0;
            done_q  <= 1'b1;
          end else begin
            cnt_q <= cnt_q - CW'(1);
          end
        end
        GAP: begin
          if (!cnt_zero) begin
            cnt_q <= cnt_q - CW'(1);
          end else if (launch) begin
            state_q <= HIGH;
            cnt_q   <= HOLD_LD;
            level_q <= 1'b1;
          end else begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= IDLE;
          cnt_q   <= '0;
          level_q <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase

      // Saturated queue drops the event and flags it.
      if (inc) begin
        if (pend_q == PMAX) begin
          ovf_q <= 1'b1;
        end else begin
          pend_q <= pend_q + PEND_W'(1);
        end
      end else if (dec) begin
        pend_q <= pend_q - PEND_W'(1);
      end
    end
  end

  assign level_o = level_q;
  assign busy_o  = busy_q;
  assign done_o  = done_q;
  assign pend_o  = pend_q;
  assign ovf_o   = ovf_q;

endmodule

// File: tb/tb_pulse_to_level.sv
// Directed bench for pulse_to_level: HOLD=4/GAP=1 and
// HOLD=1/GAP=3 instances, both with a 2-bit pending counter.
module tb_pulse_to_level;

  logic       clk;
  logic       rst;
  logic       pulse_a, clr_a;
  logic       pulse_b, clr_b;
  logic       level_a, busy_a, done_a, ovf_a;
  logic       level_b, busy_b, done_b, ovf_b;
  logic [1:0] pend_a, pend_b;

  int nvec = 0;
  int nerr = 0;

  logic [7:0] pl [0:63];
  logic       ol [0:63];

  pulse_to_level #(
    .HOLD_CYCLES(4),
    .GAP_CYCLES (1),
    .PEND_W     (2)
  ) dut_a (
    .clk_i  (clk),
    .rst_i  (rst),
    .pulse_i(pulse_a),
    .clr_i  (clr_a),
    .level_o(level_a),
    .busy_o (busy_a),
    .done_o (done_a),
    .pend_o (pend_a),
    .ovf_o  (ovf_a)
  );

  pulse_to_level #(
    .HOLD_CYCLES(1),
    .GAP_CYCLES (3),
    .PEND_W     (2)
  ) dut_b (
    .clk_i  (clk),
    .rst_i  (rst),
    .pulse_i(pulse_b),
    .clr_i  (clr_b),
    .level_o(level_b),
    .busy_o (busy_b),
    .done_o (done_b),
    .pend_o (pend_b),
    .ovf_o  (ovf_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int t,
                     input logic [7:0] obs,
                     input logic [7:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s@%0d observed %0h expected %0h",
             tag, t, obs, exp);
    end
  endtask

  function automatic logic [63:0] rng(input int lo,
                                      input int hi);
    logic [63:0] m;
    m = '0;
    for (int i = lo; i <= hi; i++) m[i] = 1'b1;
    return m;
  endfunction

  function automatic logic [63:0] b(input int i);
    return 64'd1 << i;
  endfunction

  task automatic do_reset();
    pulse_a = 1'b0;
    clr_a   = 1'b0;
    pulse_b = 1'b0;
    clr_b   = 1'b0;
    rst     = 1'b1;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Cycle t starts at the t-th rising edge after reset release.
  task automatic run(input bit sel,
                     input logic [63:0] pm,
                     input logic [63:0] cm,
                     input logic [63:0] le,
                     input logic [63:0] be,
                     input logic [63:0] de,
                     input int n);
    logic lv, bz, dn;
    for (int t = 0; t < n; t++) begin
      @(posedge clk);
      #1;
      pulse_a = !sel && pm[t];
      clr_a   = !sel && cm[t];
      pulse_b = sel && pm[t];
      clr_b   = sel && cm[t];
      lv = sel ? level_b : level_a;
      bz = sel ? busy_b  : busy_a;
      dn = sel ? done_b  : done_a;
      pl[t] = {6'd0, (sel ? pend_b : pend_a)};
      ol[t] = sel ? ovf_b : ovf_a;
      chk("level", t, {7'd0, lv}, {7'd0, le[t]});
      chk("busy",  t, {7'd0, bz}, {7'd0, be[t]});
      chk("done",  t, {7'd0, dn}, {7'd0, de[t]});
    end
    pulse_a = 1'b0;
    clr_a   = 1'b0;
    pulse_b = 1'b0;
    clr_b   = 1'b0;
  endtask

  initial begin
    logic [63:0] lq, bq, dq;

    // reset state
    pulse_a = 1'b0; clr_a = 1'b0;
    pulse_b = 1'b0; clr_b = 1'b0;
    rst = 1'b1;
    #12;
    chk("rst_level", 0, {7'd0, level_a}, 8'd0);
    chk("rst_busy",  0, {7'd0, busy_a},  8'd0);
    chk("rst_done",  0, {7'd0, done_a},  8'd0);
    chk("rst_pend",  0, {6'd0, pend_a},  8'd0);
    chk("rst_ovf",   0, {7'd0, ovf_a},   8'd0);

    // single event
    do_reset();
    run(1'b0, b(10), '0, rng(11, 14), rng(11, 15),
        b(15), 20);
    chk("single_pend", 12, pl[12], 8'd0);
    chk("single_ovf",  19, {7'd0, ol[19]}, 8'd0);

    // queued events
    lq = rng(11, 14) | rng(16, 19) | rng(21, 24);
    bq = rng(11, 25);
    dq = b(15) | b(20) | b(25);
    do_reset();
    run(1'b0, b(10) | b(12) | b(13), '0, lq, bq, dq, 28);
    chk("q_pend", 13, pl[13], 8'd1);
    chk("q_pend", 14, pl[14], 8'd2);
    chk("q_pend", 15, pl[15], 8'd2);
    chk("q_pend", 16, pl[16], 8'd1);
    chk("q_pend", 20, pl[20], 8'd1);
    chk("q_pend", 21, pl[21], 8'd0);
    chk("q_ovf",  27, {7'd0, ol[27]}, 8'd0);

    // launch with simultaneous new event
    do_reset();
    run(1'b0, b(10) | b(12) | b(15), '0, lq, bq, dq, 28);
    chk("sim_pend", 13, pl[13], 8'd1);
    chk("sim_pend", 15, pl[15], 8'd1);
    chk("sim_pend", 16, pl[16], 8'd1);
    chk("sim_pend", 20, pl[20], 8'd1);
    chk("sim_pend", 21, pl[21], 8'd0);

    // overflow, then clear of the sticky flag
    lq = rng(11, 14) | rng(16, 19) | rng(21, 24)
       | rng(26, 29) | rng(31, 34);
    bq = rng(11, 35);
    dq = b(15) | b(20) | b(25) | b(30) | b(35);
    do_reset();
    run(1'b0, rng(10, 16), b(40), lq, bq, dq, 42);
    chk("ovf_pend", 12, pl[12], 8'd1);
    chk("ovf_pend", 14, pl[14], 8'd3);
    chk("ovf_pend", 15, pl[15], 8'd3);
    chk("ovf_pend", 17, pl[17], 8'd3);
    chk("ovf_pend", 21, pl[21], 8'd2);
    chk("ovf_pend", 26, pl[26], 8'd1);
    chk("ovf_pend", 31, pl[31], 8'd0);
    chk("ovf_flag", 14, {7'd0, ol[14]}, 8'd0);
    chk("ovf_flag", 15, {7'd0, ol[15]}, 8'd1);
    chk("ovf_flag", 36, {7'd0, ol[36]}, 8'd1);
    chk("ovf_flag", 40, {7'd0, ol[40]}, 8'd1);
    chk("ovf_clr",  41, {7'd0, ol[41]}, 8'd0);

    // clear mid-HIGH with a coincident pulse
    do_reset();
    run(1'b0, rng(10, 13) | b(20), b(13),
        rng(11, 13) | rng(21, 24),
        rng(11, 13) | rng(21, 25), b(25), 28);
    chk("clr_pend", 13, pl[13], 8'd2);
    chk("clr_pend", 14, pl[14], 8'd0);
    chk("clr_pend", 22, pl[22], 8'd0);

    // asynchronous reset while HIGH
    do_reset();
    run(1'b0, b(10) | b(12), '0, rng(11, 13), rng(11, 13),
        '0, 14);
    chk("arst_pre_level", 13, {7'd0, level_a}, 8'd1);
    chk("arst_pre_pend",  13, {6'd0, pend_a},  8'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_level", 13, {7'd0, level_a}, 8'd0);
    chk("arst_busy",  13, {7'd0, busy_a},  8'd0);
    chk("arst_pend",  13, {6'd0, pend_a},  8'd0);
    chk("arst_done",  13, {7'd0, done_a},  8'd0);

    // HOLD=1, GAP=3 single event
    do_reset();
    run(1'b1, b(10), '0, b(11), rng(11, 14), b(12), 18);
    chk("h1_pend", 12, pl[12], 8'd0);

    // HOLD=1, GAP=3 back-to-back spacing
    do_reset();
    run(1'b1, b(10) | b(11), '0, b(11) | b(15),
        rng(11, 18), b(12) | b(16), 22);
    chk("h1_pend", 12, pl[12], 8'd1);
    chk("h1_pend", 14, pl[14], 8'd1);
    chk("h1_pend", 15, pl[15], 8'd0);

    $display("== %0d vectors applied, %0d miscompares ==",
             nvec, nerr);
    $finish;
  end

endmodule

// File: doc/pulse_to_level.md
Name: pulse_to_level

Overview:
- Converts single-cycle event pulses into clean level pulses with a guaranteed minimum high time and minimum low gap.
- Pulses that arrive while an output pulse is active are queued, so every edge detected upstream produces exactly one visible output pulse.
- Used in the UART controller to drive status indicators and handshake lines from one-cycle strobes such as rx-done, tx-done and error.
- Provides a pending-event count and a sticky overflow flag.

Parameters:
- HOLD_CYCLES, default 4: cycles level_o stays high per event. Legal range is 1 or more.
- GAP_CYCLES, default 1: minimum cycles level_o stays low between consecutive output pulses. Legal range is 1 or more.
- PEND_W, default 4: width of the pending-event counter. Saturates at 2^PEND_W-1.

Ports:
- clk_i, input, 1: clock. Everything samples on the rising edge.
- rst_i, input, 1: reset. Asynchronous, active-high.
- pulse_i, input, 1: event strobe. Every cycle it is sampled high counts as one event; it is not edge-detected.
- clr_i, input, 1: synchronous clear. Has priority over pulse_i.
- level_o, output, 1: stretched output pulse, registered.
- busy_o, output, 1: high whenever the FSM is not in IDLE.
- done_o, output, 1: one-cycle strobe in the first low cycle after each output pulse ends.
- pend_o, output, PEND_W: number of queued events not yet emitted.
- ovf_o, output, 1: sticky flag. Set when an event is lost to saturation.

Behaviour:
- Reset (asynchronous assert): state goes to IDLE. level_o, busy_o, done_o and ovf_o are 0; pend_o is 0; the internal counter is 0.
- FSM has three states: IDLE, HIGH, GAP.
- level_o is 1 exactly while the state is HIGH, and is driven from the state register (no combinational path from pulse_i).
- Internal down-counter is sized to hold max(HOLD_CYCLES, GAP_CYCLES)-1.
- IDLE:
  - If pulse_i is 1, go to HIGH and load cnt = HOLD_CYCLES-1.
  - Latency: pulse_i high in cycle N gives level_o high in cycles N+1 through N+HOLD_CYCLES.
- HIGH:
  - cnt decrements each cycle.
  - When cnt==0, go to GAP and load cnt = GAP_CYCLES-1.
  - done_o is 1 during the first GAP cycle.
- GAP:
  - cnt decrements each cycle.
  - When cnt==0, a launch occurs if pend_o>0 or pulse_i==1: go to HIGH and load cnt = HOLD_CYCLES-1.
  - Otherwise go to IDLE.
- Result: back-to-back events produce an output period of exactly HOLD_CYCLES+GAP_CYCLES.
- Pending counter:
  - In HIGH, or in GAP without a launch, pulse_i increments pend_o.
  - On a launch with pend_o>0: pend_o becomes pend_o - 1 + pulse_i. A simultaneous pulse therefore leaves pend_o unchanged.
  - On a launch with pend_o==0 and pulse_i: pend_o stays 0.
  - pend_o is always 0 while in IDLE.
- Saturation: if an increment is requested while pend_o == 2^PEND_W-1, pend_o holds and ovf_o goes to 1. ovf_o stays 1 until clr_i or reset.
- clr_i (synchronous, highest priority after reset):
  - Next cycle: state IDLE, level_o 0, pend_o 0, ovf_o 0, done_o 0.
  - A pulse_i in the same cycle is discarded.
  - clr_i during HIGH truncates the output pulse and does not produce done_o.
- Reset mid-operation: all outputs go to 0 immediately and asynchronously. No done_o is generated.
- With HOLD_CYCLES=1 and GAP_CYCLES=1, continuous pulse_i gives a level_o pattern of 1010..., and pend_o grows by 1 every 2 cycles until it saturates.

Test Plan (HOLD_CYCLES=4, GAP_CYCLES=1, PEND_W=2 unless stated):
- Single event: pulse_i high in cycle 10 only → level_o high in cycles 11–14; done_o high in cycle 15; busy_o high in cycles 11–15; IDLE from cycle 16.
- Queued events: pulse_i in cycles 10, 12 and 13 → pend_o=1 at cycle 13 and 2 at cycle 14; level_o high 11–14, 16–19 and 21–24; pend_o falls to 1 at 16 and 0 at 21.
- Simultaneous launch and new event: with pend_o=1, pulse_i in the final GAP cycle → launch; pend_o stays 1; next pulse starts one cycle after the GAP cycle.
- Overflow: pulse_i held high in cycles 10–16 → pend_o saturates at 3; ovf_o becomes 1 and stays 1 after all queued pulses have drained.
- Clear: clr_i in cycle 13 while HIGH, with pulse_i also high that cycle → from cycle 14, level_o=0, pend_o=0, ovf_o=0, no done_o; pulse_i in cycle 20 starts a normal pulse in cycles 21–24.
- Async reset: assert rst_i mid-HIGH between clock edges → level_o, busy_o and pend_o go to 0 before the next clk_i edge. Also repeat the single-event case with HOLD_CYCLES=1 and GAP_CYCLES=3 → level_o high for 1 cycle, minimum spacing 4 cycles.
